// File: rtl/reg_file_pkg.sv
// Shared constants for the integer register file: data width, address width,
// register count and the hard-wired zero register address.
package reg_file_pkg;

    localparam int          RF_XLEN  = 32;
    localparam int          RF_AW    = 5;
    localparam int          RF_NREGS = 2 ** RF_AW;
    localparam int unsigned X0_ADDR  = 0;

endpackage : reg_file_pkg

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register (x0 excluded), set on issue,
// cleared on writeback, synchronous active-low reset.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_rd_addr1,
    input  logic [AW-1:0] i_rd_addr2,
    output logic          o_busy1,
    output logic          o_busy2
);

    localparam int NREGS = 2 ** AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(X0_ADDR);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;
    logic [NREGS-1:0] w_pending_nxt;

    // Set is OR'd in after the clear, so a same-address issue wins over writeback.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en && (i_set_addr != ZERO_ADDR)) begin
            w_set_mask[i_set_addr] = 1'b1;
        end
        if (i_clr_en && (i_clr_addr != ZERO_ADDR)) begin
            w_clr_mask[i_clr_addr] = 1'b1;
        end
        w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_busy1 = r_pending[i_rd_addr1];
    assign o_busy2 = r_pending[i_rd_addr2];

endmodule : rf_scoreboard

// File: rtl/reg_file.sv
// Two-read/one-write register file with x0 hard-wired to zero and a pending-write
// scoreboard. Define REG_FILE_BYPASS_EN to forward wd3 to a same-cycle read of a3.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = RF_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic            we3,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2
);

    localparam int NREGS = 2 ** AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(X0_ADDR);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;
    logic [XLEN-1:0] w_rd1_stored;
    logic [XLEN-1:0] w_rd2_stored;
    logic            w_pend1;
    logic            w_pend2;
    logic            w_byp1;
    logic            w_byp2;

    assign w_wr_en = we3 && (a3 != ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[a3] <= wd3;
        end
    end

    rf_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (sb_set),
        .i_set_addr (sb_addr),
        .i_clr_en   (we3),
        .i_clr_addr (a3),
        .i_rd_addr1 (a1),
        .i_rd_addr2 (a2),
        .o_busy1    (w_pend1),
        .o_busy2    (w_pend2)
    );

    assign w_rd1_stored = (a1 == ZERO_ADDR) ? '0 : r_regs[a1];
    assign w_rd2_stored = (a2 == ZERO_ADDR) ? '0 : r_regs[a2];

`ifdef REG_FILE_BYPASS_EN
    assign w_byp1 = w_wr_en && (a1 == a3);
    assign w_byp2 = w_wr_en && (a2 == a3);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // Outputs are forced to zero while reset is held, whatever the array contains.
    assign rd1   = !rst_n ? '0 : (w_byp1 ? wd3 : w_rd1_stored);
    assign rd2   = !rst_n ? '0 : (w_byp2 ? wd3 : w_rd2_stored);
    assign busy1 = rst_n && !w_byp1 && w_pend1;
    assign busy2 = rst_n && !w_byp2 && w_pend2;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, read/write, x0, scoreboard,
// same-cycle write/read (expectation follows REG_FILE_BYPASS_EN), reset of pending.
module tb_reg_file;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic            we3;
    logic            sb_set;
    logic [AW-1:0]   sb_addr;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file #(
        .XLEN(XLEN),
        .AW  (AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a1     (a1),
        .a2     (a2),
        .a3     (a3),
        .wd3    (wd3),
        .we3    (we3),
        .sb_set (sb_set),
        .sb_addr(sb_addr),
        .rd1    (rd1),
        .rd2    (rd2),
        .busy1  (busy1),
        .busy2  (busy2)
    );

    task automatic idle();
        we3     = 1'b0;
        a3      = '0;
        wd3     = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        a1 = 5'd5;
        a2 = 5'd31;
        #1;
        total++;
        if (rd1 !== 32'h0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_p1 rd1=%h busy1=%b want 0/0", rd1, busy1);
        end
        total++;
        if (rd2 !== 32'h0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_p2 rd2=%h busy2=%b want 0/0", rd2, busy2);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a1 = AW'(i);
            a2 = AW'(31 - i);
            #1;
            total++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
                bad++;
                $display("FAIL reset_read a1=%0d rd1=%h rd2=%h busy=%b%b want all 0",
                         i, rd1, rd2, busy1, busy2);
            end
        end
    endtask

    task automatic test_write_read();
        we3 = 1'b1;
        a3  = 5'd5;
        wd3 = 32'hDEADBEEF;
        tick();
        idle();
        a1 = 5'd5;
        a2 = 5'd0;
        #1;
        total++;
        if (rd1 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_x5 rd1=%h want deadbeef", rd1);
        end
        total++;
        if (rd2 !== 32'h0) begin
            bad++;
            $display("FAIL read_x0_port2 rd2=%h want 0", rd2);
        end
    endtask

    task automatic test_x0();
        we3     = 1'b1;
        a3      = 5'd0;
        wd3     = 32'h12345678;
        sb_set  = 1'b1;
        sb_addr = 5'd0;
        tick();
        idle();
        a1 = 5'd0;
        a2 = 5'd0;
        #1;
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            bad++;
            $display("FAIL x0_write rd1=%h rd2=%h want 0", rd1, rd2);
        end
        total++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL x0_busy busy1=%b busy2=%b want 0", busy1, busy2);
        end
    endtask

    task automatic test_scoreboard();
        sb_set  = 1'b1;
        sb_addr = 5'd7;
        tick();
        idle();
        a1 = 5'd7;
        a2 = 5'd7;
        #1;
        total++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            bad++;
            $display("FAIL sb_set_x7 busy1=%b busy2=%b want 1/1", busy1, busy2);
        end
        // Writeback of x7 while x8 is issued: both must take effect.
        we3     = 1'b1;
        a3      = 5'd7;
        wd3     = 32'hA5A5A5A5;
        sb_set  = 1'b1;
        sb_addr = 5'd8;
        tick();
        idle();
        a1 = 5'd7;
        a2 = 5'd8;
        #1;
        total++;
        if (busy1 !== 1'b0 || rd1 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL sb_clear_x7 busy1=%b rd1=%h want 0/a5a5a5a5", busy1, rd1);
        end
        total++;
        if (busy2 !== 1'b1 || rd2 !== 32'h0) begin
            bad++;
            $display("FAIL sb_set_x8 busy2=%b rd2=%h want 1/0", busy2, rd2);
        end
        we3     = 1'b1;
        a3      = 5'd7;
        wd3     = 32'h0000_0001;
        sb_set  = 1'b1;
        sb_addr = 5'd7;
        tick();
        idle();
        a1 = 5'd7;
        #1;
        total++;
        if (busy1 !== 1'b1 || rd1 !== 32'h1) begin
            bad++;
            $display("FAIL sb_set_wins busy1=%b rd1=%h want 1/1", busy1, rd1);
        end
        we3 = 1'b1;
        a3  = 5'd8;
        wd3 = 32'h88;
        tick();
        idle();
        a2 = 5'd8;
        #1;
        total++;
        if (busy2 !== 1'b0 || rd2 !== 32'h88) begin
            bad++;
            $display("FAIL sb_clear_x8 busy2=%b rd2=%h want 0/88", busy2, rd2);
        end
    endtask

    task automatic test_same_cycle_read();
        logic [XLEN-1:0] exp_now;
        logic            exp_busy;
        we3 = 1'b1;
        a3  = 5'd9;
        wd3 = 32'h11;
        tick();
        idle();
        sb_set  = 1'b1;
        sb_addr = 5'd9;
        tick();
        idle();
        we3 = 1'b1;
        a3  = 5'd9;
        wd3 = 32'h55;
        a1  = 5'd9;
        a2  = 5'd9;
`ifdef REG_FILE_BYPASS_EN
        exp_now  = 32'h55;
        exp_busy = 1'b0;
`else
        exp_now  = 32'h11;
        exp_busy = 1'b1;
`endif
        #1;
        total++;
        if (rd2 !== exp_now || rd1 !== exp_now) begin
            bad++;
            $display("FAIL same_cycle_rd rd1=%h rd2=%h want %h", rd1, rd2, exp_now);
        end
        total++;
        if (busy2 !== exp_busy || busy1 !== exp_busy) begin
            bad++;
            $display("FAIL same_cycle_busy busy1=%b busy2=%b want %b", busy1, busy2, exp_busy);
        end
        tick();
        idle();
        #1;
        total++;
        if (rd2 !== 32'h55 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL next_cycle_rd rd2=%h busy2=%b want 55/0", rd2, busy2);
        end
    endtask

    task automatic test_reset_pending();
        we3 = 1'b1;
        a3  = 5'd3;
        wd3 = 32'h33;
        tick();
        idle();
        sb_set  = 1'b1;
        sb_addr = 5'd3;
        tick();
        idle();
        a1 = 5'd3;
        a2 = 5'd5;
        #1;
        total++;
        if (busy1 !== 1'b1 || rd1 !== 32'h33) begin
            bad++;
            $display("FAIL pre_reset_x3 busy1=%b rd1=%h want 1/33", busy1, rd1);
        end
        rst_n   = 1'b0;
        we3     = 1'b1;
        a3      = 5'd3;
        wd3     = 32'h77;
        sb_set  = 1'b1;
        sb_addr = 5'd3;
        #1;
        total++;
        if (busy1 !== 1'b0 || rd1 !== 32'h0 || rd2 !== 32'h0) begin
            bad++;
            $display("FAIL in_reset_x3 busy1=%b rd1=%h rd2=%h want 0/0/0", busy1, rd1, rd2);
        end
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        total++;
        if (busy1 !== 1'b0 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_x3 busy1=%b rd1=%h want 0/0", busy1, rd1);
        end
        total++;
        if (rd2 !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_x5 rd2=%h want 0", rd2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_scoreboard();
        test_same_cycle_read();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file
